// File: rtl/serial_adder_if.sv
// Start/busy/done handshake plus operand and result buses for serial_adder.
interface serial_adder_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             carry_out;
  logic             overflow;

  modport master (output start, sub, a, b,
                  input  busy, done, sum, carry_out, overflow);
  modport slave  (input  start, sub, a, b,
                  output busy, done, sum, carry_out, overflow);
endinterface

// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one full-adder cell and a carry flop, LSB first,
// WIDTH cycles per operation with a start/busy/done handshake.
module serial_adder #(
  parameter int WIDTH = 4,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input logic           clk,
  input logic           rst_n,
  serial_adder_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_r_sh;
  logic [WIDTH-1:0] r_sum;
  logic             r_c;
  logic             r_carry_out;
  logic             r_overflow;
  logic [CNT_W-1:0] r_cnt;
  logic             w_s;
  logic             w_c_next;
  logic             w_last;

  assign w_s      = r_a_sh[0] ^ r_b_sh[0] ^ r_c;
  assign w_c_next = (r_a_sh[0] & r_b_sh[0]) | (r_a_sh[0] & r_c) | (r_b_sh[0] & r_c);
  assign w_last   = (r_cnt == CNT_W'(WIDTH - 1));

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would chain the shift stages in one cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    bus.busy     = 1'b0;
    bus.done     = 1'b0;
    case (r_state)
      S_IDLE: if (bus.start) w_state_next = S_RUN;
      S_RUN: begin
        bus.busy = 1'b1;
        if (w_last) w_state_next = S_DONE;
      end
      S_DONE: begin
        bus.done     = 1'b1;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // NOTE: the datapath registers are reset too, because a mid-operation reset
  // must force sum/carry_out/overflow visibly back to zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a_sh      <= '0;
      r_b_sh      <= '0;
      r_r_sh      <= '0;
      r_sum       <= '0;
      r_c         <= 1'b0;
      r_carry_out <= 1'b0;
      r_overflow  <= 1'b0;
      r_cnt       <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            // Subtraction is A + ~B + 1: invert B here, carry-in comes from sub.
            r_a_sh <= bus.a;
            r_b_sh <= bus.sub ? ~bus.b : bus.b;
            r_c    <= bus.sub;
            r_cnt  <= '0;
          end
        end
        S_RUN: begin
          r_c    <= w_c_next;
          r_r_sh <= {w_s, r_r_sh[WIDTH-1:1]};
          r_a_sh <= r_a_sh >> 1;
          r_b_sh <= r_b_sh >> 1;
          r_cnt  <= r_cnt + CNT_W'(1);
          if (w_last) begin
            // On the MSB cycle r_c is the carry into the MSB.
            r_sum       <= {w_s, r_r_sh[WIDTH-1:1]};
            r_carry_out <= w_c_next;
            r_overflow  <= w_c_next ^ r_c;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.sum       = r_sum;
  assign bus.carry_out = r_carry_out;
  assign bus.overflow  = r_overflow;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder at WIDTH=4 and WIDTH=8, directed cases
// followed by random add/sub operations against an arithmetic reference model.
module tb_serial_adder;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  serial_adder_if #(.WIDTH(4)) if4 ();
  serial_adder_if #(.WIDTH(8)) if8 ();

  serial_adder #(.WIDTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if4));
  serial_adder #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(if8));

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    int          lat;       // rising edges from the start edge to the edge that samples done=1
    int          busy_n;
    int          done_n;
    int          hold_err;  // result outputs changing before done
    logic [35:0] rst_vec;   // {busy, done, sum, carry_out, overflow} right after a mid-run reset
  } op_res_t;

  task automatic drive(input int w, input logic st, input logic [31:0] a, input logic [31:0] b,
                       input logic sub);
    if (w == 4) begin
      if4.start = st; if4.a = a[3:0]; if4.b = b[3:0]; if4.sub = sub;
    end else begin
      if8.start = st; if8.a = a[7:0]; if8.b = b[7:0]; if8.sub = sub;
    end
  endtask

  task automatic sample(input int w, output logic bz, output logic d, output logic [31:0] s,
                        output logic c, output logic o);
    if (w == 4) begin
      bz = if4.busy; d = if4.done; s = 32'(if4.sum); c = if4.carry_out; o = if4.overflow;
    end else begin
      bz = if8.busy; d = if8.done; s = 32'(if8.sum); c = if8.carry_out; o = if8.overflow;
    end
  endtask

  // Reference: unsigned modular result, borrow/carry by magnitude comparison,
  // overflow by checking the signed result against the representable range.
  function automatic void model(input int w, input longint ua, input longint ub, input bit sub,
                                output longint s, output bit c, output bit o);
    longint m, half, sa, sb, sr;
    m    = longint'(1) << w;
    half = m / 2;
    sa   = (ua >= half) ? ua - m : ua;
    sb   = (ub >= half) ? ub - m : ub;
    sr   = sub ? sa - sb : sa + sb;
    o    = (sr >= half) || (sr < -half);
    if (sub) begin
      c = (ua >= ub);
      s = (ua - ub + m) % m;
    end else begin
      c = (ua + ub) >= m;
      s = (ua + ub) % m;
    end
  endfunction

  task automatic op(input int w, input logic [31:0] a, input logic [31:0] b, input logic sub,
                    input int restart_at, input int reset_at, output op_res_t r);
    logic bz, d, c, o, p_c, p_o, p_bz, p_d;
    logic [31:0] s, p_s;
    r.sum = '0; r.cout = 1'b0; r.ovf = 1'b0; r.lat = 0;
    r.busy_n = 0; r.done_n = 0; r.hold_err = 0; r.rst_vec = '1;
    @(negedge clk);
    sample(w, p_bz, p_d, p_s, p_c, p_o);
    drive(w, 1'b1, a, b, sub);
    @(posedge clk);
    @(negedge clk);
    drive(w, 1'b0, $urandom, $urandom, 1'($urandom));
    for (int cyc = 0; cyc <= w + 3; cyc++) begin
      if (cyc > 0) begin
        @(posedge clk);
        @(negedge clk);
      end
      sample(w, bz, d, s, c, o);
      if (reset_at >= 0 && cyc == reset_at + 1) begin
        r.rst_vec = {bz, d, s, c, o};
        rst_n     = 1'b1;
      end
      if (bz) r.busy_n++;
      if (d)  r.done_n++;
      if (d && r.lat == 0) begin
        r.lat = cyc + 1;
        r.sum = s; r.cout = c; r.ovf = o;
      end else if (r.lat == 0 && reset_at < 0 && {s, c, o} !== {p_s, p_c, p_o}) begin
        r.hold_err++;
      end
      if (restart_at >= 0 && cyc == restart_at)     drive(w, 1'b1, 32'd7, 32'd7, 1'b0);
      if (restart_at >= 0 && cyc == restart_at + 2) drive(w, 1'b0, $urandom, $urandom, 1'b0);
      if (reset_at >= 0 && cyc == reset_at)         rst_n = 1'b0;
    end
  endtask

  task automatic test_reset();
    logic bz, d, c, o;
    logic [31:0] s;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    sample(4, bz, d, s, c, o);
    n_checks++;
    if ({bz, d, s, c, o} !== 36'd0) begin
      n_fail++;
      $display("FAIL reset_w4: got busy=%b done=%b sum=%0d c=%b v=%b, want all 0", bz, d, s, c, o);
    end
    sample(8, bz, d, s, c, o);
    n_checks++;
    if ({bz, d, s, c, o} !== 36'd0) begin
      n_fail++;
      $display("FAIL reset_w8: got busy=%b done=%b sum=%0d c=%b v=%b, want all 0", bz, d, s, c, o);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_add_basic();
    op_res_t r;
    op(4, 32'd5, 32'd3, 1'b0, -1, -1, r);
    n_checks++;
    if (r.lat !== 5 || r.done_n !== 1) begin
      n_fail++;
      $display("FAIL add_5_3_timing: got lat=%0d done_n=%0d, want lat=5 done_n=1", r.lat, r.done_n);
    end
    n_checks++;
    if ({r.sum, r.cout, r.ovf} !== {32'd8, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL add_5_3: got sum=%0d c=%b v=%b, want sum=8 c=0 v=1", r.sum, r.cout, r.ovf);
    end
  endtask

  task automatic test_carry_and_sub();
    op_res_t r;
    op(4, 32'd15, 32'd1, 1'b0, -1, -1, r);
    n_checks++;
    if ({r.sum, r.cout, r.ovf} !== {32'd0, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL add_15_1: got sum=%0d c=%b v=%b, want sum=0 c=1 v=0", r.sum, r.cout, r.ovf);
    end
    op(4, 32'd3, 32'd5, 1'b1, -1, -1, r);
    n_checks++;
    if ({r.sum, r.cout, r.ovf} !== {32'd14, 1'b0, 1'b0} || r.hold_err !== 0) begin
      n_fail++;
      $display("FAIL sub_3_5: got sum=%0d c=%b v=%b hold_err=%0d, want sum=14 c=0 v=0 hold_err=0",
               r.sum, r.cout, r.ovf, r.hold_err);
    end
  endtask

  task automatic test_sub_overflow();
    op_res_t r;
    op(4, 32'd8, 32'd1, 1'b1, -1, -1, r);
    n_checks++;
    if ({r.sum, r.cout, r.ovf} !== {32'd7, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL sub_8_1: got sum=%0d c=%b v=%b, want sum=7 c=1 v=1", r.sum, r.cout, r.ovf);
    end
    n_checks++;
    if (r.busy_n !== 4 || r.done_n !== 1) begin
      n_fail++;
      $display("FAIL sub_8_1_handshake: got busy_n=%0d done_n=%0d, want busy_n=4 done_n=1",
               r.busy_n, r.done_n);
    end
  endtask

  task automatic test_start_ignored();
    op_res_t r;
    op(4, 32'd2, 32'd2, 1'b0, 1, -1, r);
    n_checks++;
    if ({r.sum, r.cout, r.ovf} !== {32'd4, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL start_ignored: got sum=%0d c=%b v=%b, want sum=4 c=0 v=0", r.sum, r.cout, r.ovf);
    end
    n_checks++;
    if (r.done_n !== 1 || r.busy_n !== 4 || r.lat !== 5) begin
      n_fail++;
      $display("FAIL start_ignored_pulses: got done_n=%0d busy_n=%0d lat=%0d, want 1 4 5",
               r.done_n, r.busy_n, r.lat);
    end
  endtask

  task automatic test_reset_mid_run();
    op_res_t r;
    op(4, 32'd6, 32'd6, 1'b0, -1, 2, r);
    n_checks++;
    if (r.rst_vec !== 36'd0) begin
      n_fail++;
      $display("FAIL mid_reset_outputs: got {busy,done,sum,c,v}=%h, want 0", r.rst_vec);
    end
    n_checks++;
    if (r.done_n !== 0) begin
      n_fail++;
      $display("FAIL mid_reset_no_done: got done_n=%0d, want 0", r.done_n);
    end
    op(4, 32'd1, 32'd1, 1'b0, -1, -1, r);
    n_checks++;
    if ({r.sum, r.cout, r.ovf} !== {32'd2, 1'b0, 1'b0} || r.lat !== 5) begin
      n_fail++;
      $display("FAIL after_reset_1_1: got sum=%0d c=%b v=%b lat=%0d, want sum=2 c=0 v=0 lat=5",
               r.sum, r.cout, r.ovf, r.lat);
    end
  endtask

  task automatic test_width8_random();
    op_res_t r;
    longint  es;
    bit      ec, eo;
    logic [31:0] a, b;
    logic        sub;
    op(8, 32'd200, 32'd100, 1'b0, -1, -1, r);
    n_checks++;
    if ({r.sum, r.cout, r.ovf} !== {32'd44, 1'b1, 1'b0} || r.lat !== 9) begin
      n_fail++;
      $display("FAIL add8_200_100: got sum=%0d c=%b v=%b lat=%0d, want sum=44 c=1 v=0 lat=9",
               r.sum, r.cout, r.ovf, r.lat);
    end
    for (int i = 0; i < 1000; i++) begin
      a   = $urandom_range(0, 255);
      b   = $urandom_range(0, 255);
      sub = 1'($urandom);
      model(8, longint'(a), longint'(b), sub, es, ec, eo);
      op(8, a, b, sub, -1, -1, r);
      n_checks++;
      if (r.sum !== 32'(es) || r.cout !== ec || r.ovf !== eo || r.lat !== 9 ||
          r.done_n !== 1 || r.busy_n !== 8 || r.hold_err !== 0) begin
        n_fail++;
        $display("FAIL rand8_%0d: a=%0d b=%0d sub=%b got sum=%0d c=%b v=%b lat=%0d done_n=%0d busy_n=%0d hold_err=%0d, want sum=%0d c=%b v=%b lat=9 done_n=1 busy_n=8 hold_err=0",
                 i, a, b, sub, r.sum, r.cout, r.ovf, r.lat, r.done_n, r.busy_n, r.hold_err,
                 es, ec, eo);
      end
    end
  endtask

  initial begin
    drive(4, 1'b0, 32'd0, 32'd0, 1'b0);
    drive(8, 1'b0, 32'd0, 32'd0, 1'b0);
    test_reset();
    test_add_basic();
    test_carry_and_sub();
    test_sub_overflow();
    test_start_ignored();
    test_reset_mid_run();
    test_width8_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
